// File: rtl/norm_rebuild_5d.sv
// norm_rebuild_5d
//   Rebuilds a 5-D vector from its magnitude and the four vectoring angle
//   codes produced by the 5-D CORDIC norm block. Four rotations are chained
//   through the rot1 port of the shared SCICA CORDIC wrapper, k = 3,2,1,0:
//   (r,0)->(r3,w4), (r3,0)->(r2,w3), (r2,0)->(r1,w2), (r1,0)->(w0,w1).
// Ports:
//   clk, nreset             clock, asynchronous active-high reset
//   start, r_in, ang_in     request, magnitude, four {quad,microRot} slots
//   W_out, done, err        rebuilt vector (w0 in LSBs), completion pulse,
//                           sticky timeout flag
//   cordic_nrst, ica_*      requester side of the wrapper rot1 port
//   cordic_rot1_*           wrapper results
module norm_rebuild_5d #(
   parameter int DIMENSIONS     = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int CORDIC_WIDTH   = 38,
   parameter int CORDIC_STAGES  = 16,
   parameter int ANGLE_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                                clk,
   input  logic                                nreset,
   input  logic                                start,
   input  logic [DATA_WIDTH-1:0]               r_in,
   input  logic [4*(CORDIC_STAGES+2)-1:0]      ang_in,
   output logic [DIMENSIONS*DATA_WIDTH-1:0]    W_out,
   output logic                                done,
   output logic                                err,
   output logic                                cordic_nrst,
   output logic                                ica_cordic_rot1_en,
   output logic [DATA_WIDTH-1:0]               ica_cordic_rot1_xin,
   output logic [DATA_WIDTH-1:0]               ica_cordic_rot1_yin,
   output logic [CORDIC_STAGES-1:0]            ica_cordic_rot1_microRot_in,
   output logic [1:0]                          ica_cordic_rot1_quad_in,
   output logic                                ica_cordic_rot1_angle_microRot_n,
   output logic                                ica_cordic_rot1_microRot_ext_vld,
   input  logic                                cordic_rot1_opvld,
   input  logic [DATA_WIDTH-1:0]               cordic_rot1_xout,
   input  logic [DATA_WIDTH-1:0]               cordic_rot1_yout
);

   localparam int SLOT_W = CORDIC_STAGES + 2;
   localparam int ANG_W  = 4 * SLOT_W;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int VEC_W  = DIMENSIONS * DATA_WIDTH;

   // The wrapper width and angle port are only carried for interface parity.
   if (DIMENSIONS != 5 || CORDIC_WIDTH < DATA_WIDTH || ANGLE_WIDTH < 1) begin : g_param_check
      $error("norm_rebuild_5d: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CRST  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_STORE = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t                    state_r, state_s;
   logic [1:0]                k_r, k_s;
   logic [CNT_W-1:0]          cnt_r, cnt_s;
   logic [DATA_WIDTH-1:0]     acc_r, acc_s;
   logic [ANG_W-1:0]          ang_r, ang_s;
   logic [DATA_WIDTH-1:0]     xcap_r, xcap_s, ycap_r, ycap_s;
   logic [DATA_WIDTH-1:0]     w_r [DIMENSIONS];
   logic [DATA_WIDTH-1:0]     w_s [DIMENSIONS];
   logic                      err_r, err_s;
   logic                      done_r, done_s;
   logic                      nrst_r, nrst_s;
   logic [VEC_W-1:0]          w_out_r, w_out_s, w_pack_s;
   logic                      en_r, en_s;
   logic [DATA_WIDTH-1:0]     xin_r, xin_s, yin_r, yin_s;
   logic [CORDIC_STAGES-1:0]  mr_r, mr_s;
   logic [1:0]                quad_r, quad_s;
   logic [SLOT_W-1:0]         slot_s;
   logic                      timeout_s;
   logic                      accept_s;

   assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
   assign accept_s  = (state_r == S_IDLE) && start;

   // State register.
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:  if (start) state_s = S_CRST; else state_s = S_IDLE;
         S_CRST:  state_s = S_ISSUE;
         S_ISSUE: state_s = S_WAIT;
         // A result arriving on the timeout cycle still counts.
         S_WAIT:  if (cordic_rot1_opvld) state_s = S_STORE;
                  else if (timeout_s)    state_s = S_FIN;
                  else                   state_s = S_WAIT;
         S_STORE: if (k_r != 2'd0) state_s = S_ISSUE; else state_s = S_FIN;
         S_FIN:   state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // Datapath and output next values; outputs are computed from the next
   // state so that every port comes straight from a flop.
   always_comb begin
      acc_s  = acc_r;
      k_s    = k_r;
      cnt_s  = cnt_r;
      ang_s  = ang_r;
      xcap_s = xcap_r;
      ycap_s = ycap_r;
      err_s  = err_r;
      for (int i = 0; i < DIMENSIONS; i++) w_s[i] = w_r[i];

      case (state_r)
         S_IDLE: begin
            if (start) begin
               acc_s = r_in;
               ang_s = ang_in;
               k_s   = 2'd3;
               err_s = 1'b0;
               for (int i = 0; i < DIMENSIONS; i++) w_s[i] = {DATA_WIDTH{1'b0}};
            end else begin
               acc_s = acc_r;
            end
         end
         S_ISSUE: cnt_s = {CNT_W{1'b0}};
         S_WAIT: begin
            if (cordic_rot1_opvld) begin
               xcap_s = cordic_rot1_xout;
               ycap_s = cordic_rot1_yout;
            end else if (timeout_s) begin
               err_s = 1'b1;
            end else begin
               cnt_s = cnt_r + CNT_W'(1'b1);
            end
         end
         S_STORE: begin
            if (k_r != 2'd0) begin
               // Rotation k yields w[k+1]; its x result feeds the next one.
               w_s[{1'b0, k_r} + 3'd1] = ycap_r;
               acc_s = xcap_r;
               k_s   = k_r - 2'd1;
            end else begin
               w_s[1] = ycap_r;
               w_s[0] = xcap_r;
            end
         end
         default: cnt_s = cnt_r;
      endcase

      slot_s = ang_s[int'(k_s) * SLOT_W +: SLOT_W];

      if (state_s == S_ISSUE) begin
         en_s   = 1'b1;
         xin_s  = acc_s;
         yin_s  = {DATA_WIDTH{1'b0}};
         mr_s   = slot_s[CORDIC_STAGES-1:0];
         quad_s = slot_s[SLOT_W-1:CORDIC_STAGES];
      end else begin
         en_s   = 1'b0;
         xin_s  = {DATA_WIDTH{1'b0}};
         yin_s  = {DATA_WIDTH{1'b0}};
         mr_s   = {CORDIC_STAGES{1'b0}};
         quad_s = 2'd0;
      end

      done_s = (state_s == S_FIN);
      nrst_s = (state_s != S_CRST);

      for (int i = 0; i < DIMENSIONS; i++) w_pack_s[i*DATA_WIDTH +: DATA_WIDTH] = w_s[i];

      if (state_s == S_FIN) begin
         w_out_s = w_pack_s;
      end else if (accept_s) begin
         w_out_s = {VEC_W{1'b0}};
      end else begin
         w_out_s = w_out_r;
      end
   end

   // Working registers and registered outputs.
   always_ff @(posedge clk or posedge nreset) begin
      if (nreset) begin
         acc_r   <= {DATA_WIDTH{1'b0}};
         k_r     <= 2'd3;
         cnt_r   <= {CNT_W{1'b0}};
         ang_r   <= {ANG_W{1'b0}};
         xcap_r  <= {DATA_WIDTH{1'b0}};
         ycap_r  <= {DATA_WIDTH{1'b0}};
         for (int i = 0; i < DIMENSIONS; i++) w_r[i] <= {DATA_WIDTH{1'b0}};
         err_r   <= 1'b0;
         done_r  <= 1'b0;
         nrst_r  <= 1'b0;
         w_out_r <= {VEC_W{1'b0}};
         en_r    <= 1'b0;
         xin_r   <= {DATA_WIDTH{1'b0}};
         yin_r   <= {DATA_WIDTH{1'b0}};
         mr_r    <= {CORDIC_STAGES{1'b0}};
         quad_r  <= 2'd0;
      end else begin
         acc_r   <= acc_s;
         k_r     <= k_s;
         cnt_r   <= cnt_s;
         ang_r   <= ang_s;
         xcap_r  <= xcap_s;
         ycap_r  <= ycap_s;
         for (int i = 0; i < DIMENSIONS; i++) w_r[i] <= w_s[i];
         err_r   <= err_s;
         done_r  <= done_s;
         nrst_r  <= nrst_s;
         w_out_r <= w_out_s;
         en_r    <= en_s;
         xin_r   <= xin_s;
         yin_r   <= yin_s;
         mr_r    <= mr_s;
         quad_r  <= quad_s;
      end
   end

   assign W_out                            = w_out_r;
   assign done                             = done_r;
   assign err                              = err_r;
   assign cordic_nrst                      = nrst_r;
   assign ica_cordic_rot1_en               = en_r;
   assign ica_cordic_rot1_microRot_ext_vld = en_r;
   assign ica_cordic_rot1_xin              = xin_r;
   assign ica_cordic_rot1_yin              = yin_r;
   assign ica_cordic_rot1_microRot_in      = mr_r;
   assign ica_cordic_rot1_quad_in          = quad_r;
   assign ica_cordic_rot1_angle_microRot_n = 1'b0;

endmodule

// File: tb/tb_norm_rebuild_5d.sv
// Directed testbench for norm_rebuild_5d. A behavioural wrapper model answers
// each rot1 issue three cycles later with values from a per-test table and
// records what was issued; each test task checks its own expectations.
module tb_norm_rebuild_5d;

   logic         clk = 1'b0;
   logic         nreset = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  r_in = 32'd0;
   logic [71:0]  ang_in = 72'd0;
   logic [159:0] W_out;
   logic         done, err, cordic_nrst;
   logic         rot1_en, ext_vld, amr_n;
   logic [31:0]  xin, yin;
   logic [15:0]  mr;
   logic [1:0]   quad;
   logic         opvld = 1'b0;
   logic [31:0]  xout = 32'd0;
   logic [31:0]  yout = 32'd0;

   int checks = 0;
   int errors = 0;

   // wrapper model state and monitors
   logic [31:0] resp_x [4];
   logic [31:0] resp_y [4];
   logic [31:0] iss_x  [4];
   logic [31:0] iss_y  [4];
   logic [15:0] iss_mr [4];
   logic [1:0]  iss_q  [4];
   logic        iss_ev [4];
   int  iss_n = 0, en_cnt = 0, done_cnt = 0, nrst_low = 0;
   int  mdl_cnt = 0, mdl_idx = 0;
   bit  mdl_busy = 1'b0, mdl_mute = 1'b0;

   norm_rebuild_5d dut (
      .clk                              (clk),
      .nreset                           (nreset),
      .start                            (start),
      .r_in                             (r_in),
      .ang_in                           (ang_in),
      .W_out                            (W_out),
      .done                             (done),
      .err                              (err),
      .cordic_nrst                      (cordic_nrst),
      .ica_cordic_rot1_en               (rot1_en),
      .ica_cordic_rot1_xin              (xin),
      .ica_cordic_rot1_yin              (yin),
      .ica_cordic_rot1_microRot_in      (mr),
      .ica_cordic_rot1_quad_in          (quad),
      .ica_cordic_rot1_angle_microRot_n (amr_n),
      .ica_cordic_rot1_microRot_ext_vld (ext_vld),
      .cordic_rot1_opvld                (opvld),
      .cordic_rot1_xout                 (xout),
      .cordic_rot1_yout                 (yout)
   );

   always #5 clk = ~clk;

   // Wrapper model: latency 3 cycles after the issue strobe.
   always @(negedge clk) begin
      opvld = 1'b0;
      if (nreset) begin
         mdl_busy = 1'b0;
      end else begin
         if (mdl_busy) begin
            if (mdl_cnt == 0) begin
               opvld = 1'b1;
               xout = resp_x[mdl_idx];
               yout = resp_y[mdl_idx];
               mdl_busy = 1'b0;
            end else begin
               mdl_cnt = mdl_cnt - 1;
            end
         end
         if (rot1_en) begin
            mdl_idx = (iss_n < 4) ? iss_n : 3;
            iss_x[mdl_idx] = xin;
            iss_y[mdl_idx] = yin;
            iss_mr[mdl_idx] = mr;
            iss_q[mdl_idx] = quad;
            iss_ev[mdl_idx] = ext_vld;
            iss_n = iss_n + 1;
            en_cnt = en_cnt + 1;
            if (!mdl_mute) begin
               mdl_busy = 1'b1;
               mdl_cnt = 2;
            end
         end
         if (done) done_cnt = done_cnt + 1;
         if (!cordic_nrst) nrst_low = nrst_low + 1;
      end
   end

   // Issues one request and waits (bounded) for done; cyc = -1 if it never came.
   task automatic run_op(input logic [31:0] r, input logic [71:0] a, input int busy_at, output int cyc);
      done_cnt = 0; en_cnt = 0; iss_n = 0; nrst_low = 0;
      @(negedge clk);
      r_in = r; ang_in = a; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = -1;
      for (int c = 0; c < 400; c++) begin
         if (done) begin
            cyc = c;
            break;
         end
         start = (c == busy_at || c == busy_at + 6) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   localparam logic [71:0] ANG_A = {2'd0, 16'h8001, 2'd3, 16'h3333, 2'd2, 16'h2222, 2'd1, 16'h1111};
   localparam logic [71:0] ANG_B = {2'd0, 16'h0001, 2'd3, 16'hFFFF, 2'd1, 16'h5A5A, 2'd2, 16'hA5A5};
   // (0,0,0,4.0,3.0) as {w4..w0}
   localparam logic [159:0] W_A = {32'h0030_0000, 32'h0040_0000, 32'd0, 32'd0, 32'd0};
   localparam logic [159:0] W_B = {32'd5242880, 32'd20971520, 32'hFFC0_0000, 32'd0, 32'd3145728};

   task automatic load_a();
      resp_x = '{32'h0040_0000, 32'd0, 32'd0, 32'd0};
      resp_y = '{32'h0030_0000, 32'h0040_0000, 32'd0, 32'd0};
   endtask

   task automatic test_reset();
      nreset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (W_out !== 160'd0) begin errors++; $display("FAIL reset_wout got %h want 0", W_out); end
      checks++; if ({done, err, cordic_nrst} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {done, err, cordic_nrst}); end
      checks++; if ({rot1_en, ext_vld, amr_n, quad} !== 5'd0 || xin !== 32'd0 || yin !== 32'd0 || mr !== 16'd0) begin
         errors++; $display("FAIL reset_ica got en=%b xin=%h mr=%h want all 0", rot1_en, xin, mr); end
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (cordic_nrst !== 1'b1) begin errors++; $display("FAIL idle_nrst got %b want 1", cordic_nrst); end
   endtask

   task automatic test_round_trip();
      int cyc;
      logic [71:0] a;
      a = ANG_A;
      load_a();
      run_op(32'h0050_0000, a, -100, cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL rt_done got no done want done"); end
      checks++; if (W_out !== W_A) begin errors++; $display("FAIL rt_wout got %h want %h", W_out, W_A); end
      checks++; if (done_cnt !== 1 || err !== 1'b0) begin errors++; $display("FAIL rt_pulse got done=%0d err=%b want 1,0", done_cnt, err); end
      checks++; if (en_cnt !== 4 || nrst_low !== 1) begin errors++; $display("FAIL rt_counts got en=%0d nrst_low=%0d want 4,1", en_cnt, nrst_low); end
      checks++; if (iss_x[0] !== 32'h0050_0000 || iss_x[1] !== 32'h0040_0000 || iss_x[2] !== 32'd0 || iss_x[3] !== 32'd0) begin
         errors++; $display("FAIL rt_xin got %h %h %h %h want 500000 400000 0 0", iss_x[0], iss_x[1], iss_x[2], iss_x[3]); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (iss_mr[i] !== a[(3-i)*18 +: 16] || iss_q[i] !== a[(3-i)*18+16 +: 2] || iss_y[i] !== 32'd0 || iss_ev[i] !== 1'b1) begin
            errors++; $display("FAIL rt_code%0d got mr=%h q=%0d y=%h ev=%b want mr=%h q=%0d y=0 ev=1", i, iss_mr[i], iss_q[i], iss_y[i], iss_ev[i], a[(3-i)*18 +: 16], a[(3-i)*18+16 +: 2]); end
      end
   endtask

   task automatic test_zero_mag();
      int cyc;
      resp_x = '{32'd0, 32'd0, 32'd0, 32'd0};
      resp_y = '{32'd0, 32'd0, 32'd0, 32'd0};
      run_op(32'd0, ANG_B, -100, cyc);
      checks++; if (W_out !== 160'd0) begin errors++; $display("FAIL zero_wout got %h want 0", W_out); end
      checks++; if (done_cnt !== 1 || en_cnt !== 4) begin errors++; $display("FAIL zero_counts got done=%0d en=%0d want 1,4", done_cnt, en_cnt); end
   endtask

   task automatic test_mixed_signs();
      int cyc;
      resp_x = '{32'd21616946, 32'd5242880, 32'd3145728, 32'd3145728};
      resp_y = '{32'd5242880, 32'd20971520, 32'hFFC0_0000, 32'd0};
      run_op(32'd22243657, ANG_B, -100, cyc);
      checks++; if (W_out !== W_B) begin errors++; $display("FAIL mix_wout got %h want %h", W_out, W_B); end
      checks++; if (iss_x[1] !== 32'd21616946 || iss_x[2] !== 32'd5242880 || iss_x[3] !== 32'd3145728) begin
         errors++; $display("FAIL mix_chain got %0d %0d %0d want 21616946 5242880 3145728", iss_x[1], iss_x[2], iss_x[3]); end
      checks++; if (iss_mr[0] !== 16'h0001 || iss_q[3] !== 2'd2) begin errors++; $display("FAIL mix_codes got mr0=%h q3=%0d want 0001,2", iss_mr[0], iss_q[3]); end
      checks++; if (done_cnt !== 1 || err !== 1'b0) begin errors++; $display("FAIL mix_pulse got done=%0d err=%b want 1,0", done_cnt, err); end
   endtask

   task automatic test_timeout();
      int cyc;
      mdl_mute = 1'b1;
      run_op(32'h0050_0000, ANG_A, -100, cyc);
      mdl_mute = 1'b0;
      checks++; if (cyc < 64 || cyc > 68) begin errors++; $display("FAIL to_latency got %0d want 64..68", cyc); end
      checks++; if (err !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL to_flags got err=%b done=%0d want 1,1", err, done_cnt); end
      checks++; if (W_out !== 160'd0 || en_cnt !== 1) begin errors++; $display("FAIL to_wout got %h en=%0d want 0,1", W_out, en_cnt); end
      repeat (4) @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", err); end
      load_a();
      run_op(32'h0050_0000, ANG_A, -100, cyc);
      checks++; if (err !== 1'b0 || W_out !== W_A) begin errors++; $display("FAIL to_recover got err=%b W=%h want 0,%h", err, W_out, W_A); end
   endtask

   task automatic test_busy_start();
      int cyc;
      load_a();
      run_op(32'h0050_0000, ANG_A, 3, cyc);
      checks++; if (en_cnt !== 4 || done_cnt !== 1) begin errors++; $display("FAIL busy_counts got en=%0d done=%0d want 4,1", en_cnt, done_cnt); end
      checks++; if (W_out !== W_A) begin errors++; $display("FAIL busy_wout got %h want %h", W_out, W_A); end
      repeat (4) @(negedge clk);
      checks++; if (en_cnt !== 4) begin errors++; $display("FAIL busy_idle got en=%0d want 4", en_cnt); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      load_a();
      done_cnt = 0; en_cnt = 0; iss_n = 0;
      @(negedge clk);
      r_in = 32'h0050_0000; ang_in = ANG_A; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (en_cnt >= 2) break;
         @(negedge clk);
      end
      @(negedge clk);
      checks++; if (en_cnt !== 2) begin errors++; $display("FAIL rm_reach got en=%0d want 2", en_cnt); end
      nreset = 1'b1;
      #1;
      checks++; if (W_out !== 160'd0 || {done, err, cordic_nrst, rot1_en} !== 4'b0000) begin
         errors++; $display("FAIL rm_async got W=%h flags=%b want 0,0000", W_out, {done, err, cordic_nrst, rot1_en}); end
      repeat (3) @(negedge clk);
      checks++; if (cordic_nrst !== 1'b0 || done !== 1'b0 || done_cnt !== 0) begin
         errors++; $display("FAIL rm_held got nrst=%b done=%b cnt=%0d want 0,0,0", cordic_nrst, done, done_cnt); end
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      run_op(32'h0050_0000, ANG_A, -100, cyc);
      checks++; if (W_out !== W_A || done_cnt !== 1 || en_cnt !== 4) begin
         errors++; $display("FAIL rm_fresh got W=%h done=%0d en=%0d want %h,1,4", W_out, done_cnt, en_cnt, W_A); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         resp_x[i] = 32'd0; resp_y[i] = 32'd0;
         iss_x[i] = 32'd0; iss_y[i] = 32'd0; iss_mr[i] = 16'd0; iss_q[i] = 2'd0; iss_ev[i] = 1'b0;
      end
      test_reset();
      test_round_trip();
      test_zero_mag();
      test_mixed_signs();
      test_timeout();
      test_busy_start();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
